// File: rtl/e203_exu_ordwbck.sv
// In-order write-back arbiter: per-channel FIFOs drain to the regfile in OITF retire order with 1-cycle latency.
// The selected head stays stable while wbck_o_ready=0, and inputs stall only when full. E203_ORDWBCK_BYPASS_EN adds a zero-latency bypass.
module e203_exu_ordwbck #(
  parameter int CHNL_NUM = 2,
  parameter int DW       = 32,
  parameter int RFIDX_W  = 5,
  parameter int ITAG_W   = 1,
  parameter int BUF_DEP  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHNL_NUM-1:0]         wbck_i_valid,
  output logic [CHNL_NUM-1:0]         wbck_i_ready,
  input  logic [CHNL_NUM*DW-1:0]      wbck_i_wdat,
  input  logic [CHNL_NUM*RFIDX_W-1:0] wbck_i_rdidx,
  input  logic [CHNL_NUM-1:0]         wbck_i_rdwen,
  input  logic [CHNL_NUM*ITAG_W-1:0]  wbck_i_itag,
  input  logic [CHNL_NUM-1:0]         wbck_i_trk,
  input  logic                        oitf_empty,
  input  logic [ITAG_W-1:0]           oitf_ret_ptr,
  output logic                        oitf_ret_ena,
  output logic                        wbck_o_valid,
  input  logic                        wbck_o_ready,
  output logic [DW-1:0]               wbck_o_wdat,
  output logic [RFIDX_W-1:0]          wbck_o_rdidx,
  output logic [CHNL_NUM*3-1:0]       buf_cnt
);
  localparam int PW      = (BUF_DEP > 1) ? $clog2(BUF_DEP) : 1;
  localparam int SW      = (CHNL_NUM > 1) ? $clog2(CHNL_NUM) : 1;
  localparam int EW      = DW + RFIDX_W + ITAG_W + 2;
  // Entry layout, MSB..LSB: {wdat, rdidx, rdwen, itag, trk}
  localparam int RDWEN_B = ITAG_W + 1;
  localparam int RDIDX_L = ITAG_W + 2;

  logic [EW-1:0]       mem_q    [CHNL_NUM][BUF_DEP];
  logic [PW-1:0]       wptr_q   [CHNL_NUM];
  logic [PW-1:0]       wptr_d   [CHNL_NUM];
  logic [PW-1:0]       rptr_q   [CHNL_NUM];
  logic [PW-1:0]       rptr_d   [CHNL_NUM];
  logic [2:0]          cnt_q    [CHNL_NUM];
  logic [2:0]          cnt_d    [CHNL_NUM];
  logic [EW-1:0]       in_ent   [CHNL_NUM];
  logic [EW-1:0]       head_ent [CHNL_NUM];
  logic [CHNL_NUM-1:0] head_tel, head_uel, byp_tel, byp_uel, push, pop_ch;
  logic                sel_vld, sel_byp, pop;
  logic [SW-1:0]       sel_idx;
  logic [EW-1:0]       sel_ent;

  function automatic logic elig_trk(input logic [EW-1:0] e, input logic oe, input logic [ITAG_W-1:0] ptr);
    return e[0] & ~oe & (e[1 +: ITAG_W] == ptr);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < CHNL_NUM; k++) begin
      in_ent[k]   = {wbck_i_wdat[k*DW +: DW], wbck_i_rdidx[k*RFIDX_W +: RFIDX_W], wbck_i_rdwen[k],
                     wbck_i_itag[k*ITAG_W +: ITAG_W], wbck_i_trk[k]};
      head_ent[k] = mem_q[k][rptr_q[k]];
      head_tel[k] = (cnt_q[k] != 3'd0) & elig_trk(head_ent[k], oitf_empty, oitf_ret_ptr);
      head_uel[k] = (cnt_q[k] != 3'd0) & ~head_ent[k][0] & oitf_empty;
      byp_tel[k]  = 1'b0;
      byp_uel[k]  = 1'b0;
`ifdef E203_ORDWBCK_BYPASS_EN
      byp_tel[k]  = wbck_i_valid[k] & (cnt_q[k] == 3'd0) & elig_trk(in_ent[k], oitf_empty, oitf_ret_ptr);
      byp_uel[k]  = wbck_i_valid[k] & (cnt_q[k] == 3'd0) & ~wbck_i_trk[k] & oitf_empty;
`endif
    end
  end

  // Priority: tracked heads, untracked heads, then tracked/untracked bypass; lowest index first.
  always_comb begin
    sel_vld = 1'b0;
    sel_byp = 1'b0;
    sel_idx = '0;
    sel_ent = '0;
    for (int k = 0; k < CHNL_NUM; k++)
      if (!sel_vld && head_tel[k]) begin sel_vld = 1'b1; sel_idx = SW'(k); sel_ent = head_ent[k]; end
    for (int k = 0; k < CHNL_NUM; k++)
      if (!sel_vld && head_uel[k]) begin sel_vld = 1'b1; sel_idx = SW'(k); sel_ent = head_ent[k]; end
    for (int k = 0; k < CHNL_NUM; k++)
      if (!sel_vld && byp_tel[k]) begin sel_vld = 1'b1; sel_byp = 1'b1; sel_idx = SW'(k); sel_ent = in_ent[k]; end
    for (int k = 0; k < CHNL_NUM; k++)
      if (!sel_vld && byp_uel[k]) begin sel_vld = 1'b1; sel_byp = 1'b1; sel_idx = SW'(k); sel_ent = in_ent[k]; end
  end

  // A result with no regfile write retires without waiting for the write port.
  assign pop          = sel_vld & (~sel_ent[RDWEN_B] | wbck_o_ready);
  assign wbck_o_valid = sel_vld & sel_ent[RDWEN_B];
  assign wbck_o_wdat  = sel_ent[EW-1 -: DW];
  assign wbck_o_rdidx = sel_ent[RDIDX_L +: RFIDX_W];
  assign oitf_ret_ena = pop & sel_ent[0];

  always_comb begin
    for (int k = 0; k < CHNL_NUM; k++) begin
      wbck_i_ready[k]    = (cnt_q[k] != 3'(BUF_DEP));
      pop_ch[k]          = pop & ~sel_byp & (sel_idx == SW'(k));
      push[k]            = wbck_i_valid[k] & wbck_i_ready[k] & ~(pop & sel_byp & (sel_idx == SW'(k)));
      wptr_d[k]          = push[k]   ? ptr_inc(wptr_q[k]) : wptr_q[k];
      rptr_d[k]          = pop_ch[k] ? ptr_inc(rptr_q[k]) : rptr_q[k];
      cnt_d[k]           = cnt_q[k];
      if (push[k] && !pop_ch[k])      cnt_d[k] = cnt_q[k] + 3'd1;
      else if (!push[k] && pop_ch[k]) cnt_d[k] = cnt_q[k] - 3'd1;
      buf_cnt[k*3 +: 3]  = cnt_q[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CHNL_NUM; k++)
      if (push[k]) mem_q[k][wptr_q[k]] <= in_ent[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHNL_NUM; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < CHNL_NUM; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  a_one_tracked_match: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(head_tel | byp_tel));
  a_sel_tag_match: assert property (@(posedge clk) disable iff (!rst_n)
    (sel_vld & sel_ent[0]) |-> (sel_ent[1 +: ITAG_W] == oitf_ret_ptr));
endmodule

// File: tb/tb_e203_exu_ordwbck.sv
// Self-checking bench for e203_exu_ordwbck: directed scenarios plus randomized traffic against a queue model.
module tb_e203_exu_ordwbck;
  localparam int BUF_DEP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wbck_i_valid, wbck_i_ready, wbck_i_rdwen, wbck_i_trk, wbck_i_itag;
  logic [63:0] wbck_i_wdat;
  logic [9:0]  wbck_i_rdidx;
  logic        oitf_empty, oitf_ret_ena, wbck_o_valid, wbck_o_ready;
  logic [0:0]  oitf_ret_ptr;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx;
  logic [5:0]  buf_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        rdwen;
    logic        itag;
    logic        trk;
  } ent_t;

  always #5 clk = ~clk;

  e203_exu_ordwbck #(.CHNL_NUM(2), .DW(32), .RFIDX_W(5), .ITAG_W(1), .BUF_DEP(BUF_DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbck_i_valid(wbck_i_valid), .wbck_i_ready(wbck_i_ready), .wbck_i_wdat(wbck_i_wdat),
    .wbck_i_rdidx(wbck_i_rdidx), .wbck_i_rdwen(wbck_i_rdwen), .wbck_i_itag(wbck_i_itag),
    .wbck_i_trk(wbck_i_trk), .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr),
    .oitf_ret_ena(oitf_ret_ena), .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready),
    .wbck_o_wdat(wbck_o_wdat), .wbck_o_rdidx(wbck_o_rdidx), .buf_cnt(buf_cnt)
  );

  function automatic ent_t mk(input logic [31:0] w, input logic [4:0] r, input logic we,
                              input logic t, input logic tr);
    ent_t e;
    e.wdat = w; e.rdidx = r; e.rdwen = we; e.itag = t; e.trk = tr;
    return e;
  endfunction

  task automatic clear_inputs();
    wbck_i_valid = '0; wbck_i_wdat = '0; wbck_i_rdidx = '0;
    wbck_i_rdwen = '0; wbck_i_itag = '0; wbck_i_trk = '0;
  endtask

  task automatic drive_ch(input int k, input ent_t e);
    wbck_i_valid[k] = 1'b1;
    wbck_i_wdat[k*32 +: 32] = e.wdat;
    wbck_i_rdidx[k*5 +: 5] = e.rdidx;
    wbck_i_rdwen[k] = e.rdwen;
    wbck_i_itag[k] = e.itag;
    wbck_i_trk[k] = e.trk;
  endtask

  task automatic test_reset();
    clear_inputs(); oitf_empty = 1'b1; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b0; rst_n = 1'b0;
    #12;
    n_checks++; if (wbck_i_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", wbck_i_ready); end
    n_checks++; if (wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", wbck_o_valid); end
    n_checks++; if (oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL reset_ret: got %b want 0", oitf_ret_ena); end
    n_checks++; if (buf_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", buf_cnt); end
    n_checks++; if ({wbck_o_wdat, wbck_o_rdidx} !== 37'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0", wbck_o_wdat, wbck_o_rdidx); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    oitf_empty = 1'b1; wbck_o_ready = 1'b1; drive_ch(0, mk(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
`ifdef E203_ORDWBCK_BYPASS_EN
    n_checks++; if (wbck_o_valid !== 1'b1 || wbck_o_rdidx !== 5'd5) begin n_fail++; $display("FAIL bypass_same_cycle: got v=%b rd=%0d want v=1 rd=5", wbck_o_valid, wbck_o_rdidx); end
    n_checks++; if (buf_cnt !== 6'd0) begin n_fail++; $display("FAIL bypass_cnt: got %h want 0", buf_cnt); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    n_checks++; if (buf_cnt !== 6'd0 || wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_after: got cnt=%h v=%b want 0/0", buf_cnt, wbck_o_valid); end
`else
    n_checks++; if (wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b want 0", wbck_o_valid); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    n_checks++; if (wbck_o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", wbck_o_valid); end
    n_checks++; if (wbck_o_rdidx !== 5'd5 || wbck_o_wdat !== 32'h1234) begin n_fail++; $display("FAIL single_data: got rd=%0d wd=%h want 5/1234", wbck_o_rdidx, wbck_o_wdat); end
    n_checks++; if (oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL single_ret: got %b want 0", oitf_ret_ena); end
    n_checks++; if (buf_cnt !== 6'b000_001) begin n_fail++; $display("FAIL single_cnt: got %b want 000001", buf_cnt); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (buf_cnt !== 6'd0 || wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got cnt=%h v=%b want 0/0", buf_cnt, wbck_o_valid); end
`endif
  endtask

  task automatic test_order();
    @(posedge clk); #1;
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b1;
    clear_inputs(); drive_ch(1, mk(32'hAA, 5'd7, 1'b1, 1'b1, 1'b1));
    @(negedge clk);
    @(posedge clk); #1; clear_inputs(); drive_ch(0, mk(32'h55, 5'd3, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    n_checks++; if (wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL order_wait: got %b want 0", wbck_o_valid); end
    n_checks++; if (buf_cnt !== 6'b001_000) begin n_fail++; $display("FAIL order_cnt: got %b want 001000", buf_cnt); end
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat} !== {1'b1, 1'b1, 5'd3, 32'h55}) begin n_fail++; $display("FAIL order_first: got v=%b r=%b rd=%0d wd=%h want 1 1 3 55", wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat); end
    @(posedge clk); #1; oitf_ret_ptr = 1'b1;
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat} !== {1'b1, 1'b1, 5'd7, 32'hAA}) begin n_fail++; $display("FAIL order_second: got v=%b r=%b rd=%0d wd=%h want 1 1 7 aa", wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat); end
    @(posedge clk); #1; oitf_empty = 1'b1; oitf_ret_ptr = 1'b0;
    @(negedge clk);
    n_checks++; if (buf_cnt !== 6'd0 || oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL order_drain: got cnt=%h r=%b want 0/0", buf_cnt, oitf_ret_ena); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b0;
    drive_ch(0, mk(32'hA0, 5'd1, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    n_checks++; if (wbck_i_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b want 1", wbck_i_ready[0]); end
    @(posedge clk); #1; drive_ch(0, mk(32'hA1, 5'd2, 1'b1, 1'b1, 1'b1));
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena, wbck_o_rdidx} !== {1'b1, 1'b0, 5'd1}) begin n_fail++; $display("FAIL bp_hold1: got v=%b r=%b rd=%0d want 1 0 1", wbck_o_valid, oitf_ret_ena, wbck_o_rdidx); end
    @(posedge clk); #1; drive_ch(0, mk(32'hA2, 5'd3, 1'b1, 1'b0, 1'b1));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (wbck_i_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", wbck_i_ready[0]); end
      n_checks++; if (buf_cnt[2:0] !== 3'd2) begin n_fail++; $display("FAIL bp_full_cnt: got %0d want 2", buf_cnt[2:0]); end
      n_checks++; if ({wbck_o_valid, wbck_o_rdidx, wbck_o_wdat} !== {1'b1, 5'd1, 32'hA0}) begin n_fail++; $display("FAIL bp_stable: got v=%b rd=%0d wd=%h want 1 1 a0", wbck_o_valid, wbck_o_rdidx, wbck_o_wdat); end
      if (c == 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; clear_inputs(); wbck_o_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat} !== {1'b1, 1'b1, 5'd1, 32'hA0}) begin n_fail++; $display("FAIL bp_rel1: got v=%b r=%b rd=%0d wd=%h want 1 1 1 a0", wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat); end
    @(posedge clk); #1; oitf_ret_ptr = 1'b1;
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat} !== {1'b1, 1'b1, 5'd2, 32'hA1}) begin n_fail++; $display("FAIL bp_rel2: got v=%b r=%b rd=%0d wd=%h want 1 1 2 a1", wbck_o_valid, oitf_ret_ena, wbck_o_rdidx, wbck_o_wdat); end
    @(posedge clk); #1; oitf_empty = 1'b1; oitf_ret_ptr = 1'b0;
    @(negedge clk);
    n_checks++; if (buf_cnt !== 6'd0 || wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got cnt=%h v=%b want 0/0", buf_cnt, wbck_o_valid); end
  endtask

  task automatic test_rdwen0();
    @(posedge clk); #1;
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b0;
    drive_ch(1, mk(32'hBEEF, 5'd9, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena} !== 2'b01) begin n_fail++; $display("FAIL nowen_pop: got v=%b r=%b want 0 1", wbck_o_valid, oitf_ret_ena); end
    n_checks++; if (buf_cnt !== 6'b001_000) begin n_fail++; $display("FAIL nowen_cnt: got %b want 001000", buf_cnt); end
    @(posedge clk); #1; oitf_empty = 1'b1;
    @(negedge clk);
    n_checks++; if (buf_cnt !== 6'd0 || oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL nowen_after: got cnt=%h r=%b want 0/0", buf_cnt, oitf_ret_ena); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b1; wbck_o_ready = 1'b0;
    drive_ch(0, mk(32'hC0, 5'd4, 1'b1, 1'b0, 1'b1));
    drive_ch(1, mk(32'hC1, 5'd6, 1'b1, 1'b0, 1'b1));
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    n_checks++; if (buf_cnt !== 6'b001_001) begin n_fail++; $display("FAIL rstmid_pre: got %b want 001001", buf_cnt); end
    #2; rst_n = 1'b0; #1;
    n_checks++; if (buf_cnt !== 6'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %h want 0", buf_cnt); end
    n_checks++; if ({wbck_i_ready, wbck_o_valid, oitf_ret_ena} !== 4'b1100) begin n_fail++; $display("FAIL rstmid_outs: got rdy=%b v=%b r=%b want 11 0 0", wbck_i_ready, wbck_o_valid, oitf_ret_ena); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({wbck_o_valid, oitf_ret_ena} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ghost: got v=%b r=%b want 0 0", wbck_o_valid, oitf_ret_ena); end
    @(posedge clk); #1; oitf_empty = 1'b1;
  endtask

  task automatic test_random();
    ent_t mq[2][$];
    ent_t pend[2][$];
    logic oq[$];
    for (int r = 0; r < 60; r++) begin
      bit         trk_round = 1'($urandom_range(0, 1));
      int         n = $urandom_range(1, trk_round ? 2 : 4);
      logic       tag0 = 1'($urandom_range(0, 1));
      int         cyc = 0;
      for (int i = 0; i < n; i++) begin
        ent_t e;
        int   ch = $urandom_range(0, 1);
        e.wdat = $urandom; e.rdidx = 5'($urandom); e.rdwen = ($urandom_range(0, 3) != 0);
        e.trk = trk_round; e.itag = trk_round ? tag0 + 1'(i) : 1'($urandom_range(0, 1));
        pend[ch].push_back(e);
        if (trk_round) oq.push_back(e.itag);
      end
      while ((pend[0].size() + pend[1].size() + mq[0].size() + mq[1].size() + oq.size()) != 0 && cyc < 200) begin
        bit [1:0]   erdy;
        int         sel = -1;
        ent_t       se = '0;
        bit         epop, eret, evld;
        logic [46:0] got, exp;
        @(posedge clk); #1;
        clear_inputs();
        oitf_empty = (oq.size() == 0);
        oitf_ret_ptr = (oq.size() != 0) ? oq[0] : 1'b0;
        wbck_o_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 2; k++)
          if (pend[k].size() != 0 && $urandom_range(0, 1) == 1) drive_ch(k, pend[k][0]);
        @(negedge clk);
        for (int k = 0; k < 2; k++) erdy[k] = (mq[k].size() < BUF_DEP);
        for (int k = 0; k < 2; k++)
          if (sel < 0 && mq[k].size() != 0 && mq[k][0].trk && oq.size() != 0 && mq[k][0].itag == oq[0]) sel = k;
        for (int k = 0; k < 2; k++)
          if (sel < 0 && mq[k].size() != 0 && !mq[k][0].trk && oq.size() == 0) sel = k;
        if (sel >= 0) se = mq[sel][0];
        evld = (sel >= 0) && se.rdwen;
        epop = (sel >= 0) && (!se.rdwen || wbck_o_ready);
        eret = epop && se.trk;
        exp = {erdy, evld, eret, evld ? se.rdidx : 5'd0, evld ? se.wdat : 32'd0,
               3'(mq[1].size()), 3'(mq[0].size())};
        got = {wbck_i_ready, wbck_o_valid, oitf_ret_ena, evld ? wbck_o_rdidx : 5'd0,
               evld ? wbck_o_wdat : 32'd0, buf_cnt};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rand_r%0d_c%0d: got rdy/v/ret/rd/wd/cnt=%h want %h", r, cyc, got, exp);
        end
        if (epop) void'(mq[sel].pop_front());
        if (eret) void'(oq.pop_front());
        for (int k = 0; k < 2; k++)
          if (wbck_i_valid[k] && erdy[k]) mq[k].push_back(pend[k].pop_front());
        cyc++;
      end
      n_checks++;
      if (cyc >= 200) begin
        n_fail++;
        $display("FAIL rand_timeout_r%0d: drained=0 want 1", r);
        for (int k = 0; k < 2; k++) begin mq[k].delete(); pend[k].delete(); end
        oq.delete();
        @(negedge clk); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      end
    end
    @(posedge clk); #1; clear_inputs(); oitf_empty = 1'b1; oitf_ret_ptr = 1'b0;
  endtask

  initial begin
    clear_inputs();
    oitf_empty = 1'b1; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b0;
    test_reset();
    test_single();
    test_order();
    test_backpressure();
    test_rdwen0();
    test_reset_mid();
`ifndef E203_ORDWBCK_BYPASS_EN
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
